// File: rtl/lj16_frame_deserializer.sv
// Recovers aligned L/R sample pairs from a left-justified serial stream into a valid/ready pair FIFO.
// Optional: define LJ16_MONO_MIX_EN to add the out_mono (L+R)>>>1 output.
module lj16_frame_deserializer #(
    parameter int DATA_BITS  = 16,
    parameter int SLOT_BITS  = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 bck,
    input  logic                 rst,
    input  logic                 lj_bck,
    input  logic                 lj_data,
    input  logic                 lj_lrck,
    output logic [DATA_BITS-1:0] out_left,
    output logic [DATA_BITS-1:0] out_right,
`ifdef LJ16_MONO_MIX_EN
    output logic [DATA_BITS-1:0] out_mono,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DB5 = 5'(DATA_BITS);
    localparam logic [4:0] SB5 = 5'(SLOT_BITS);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {SEEK = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} state_t;

    logic                 lj_bck_r, lj_bck_rr, lj_data_r, lj_lrck_r;
    logic                 lrck_prev_reg;
    logic [4:0]           cnt_reg, cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] left_hold_reg, left_hold_next;
    state_t               state_reg, state_next;
    logic                 push_next, err_next;
    logic                 push_reg, frame_err_reg, overrun_reg;
    logic [DATA_BITS-1:0] push_left_reg, push_right_reg;

    logic [DATA_BITS-1:0] mem_left  [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_right [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_reg, rd_ptr_reg, level;
    logic                 s, trans, rise, word_done, long_slot, full, pop, wr_en;

    // Rising edge of the once-registered lj_bck is the only sampling point.
    assign s     = lj_bck_r & ~lj_bck_rr;
    assign trans = s & (lj_lrck_r != lrck_prev_reg);
    assign rise  = trans & lj_lrck_r;

    always_comb begin
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        if (s) begin
            if (trans) begin
                cnt_next      = 5'd1;
                shift_next    = '0;
                shift_next[0] = lj_data_r;
            end else begin
                if (cnt_reg != 5'd31)
                    cnt_next = cnt_reg + 5'd1;
                if (cnt_reg < DB5)
                    shift_next = {shift_reg[DATA_BITS-2:0], lj_data_r};
            end
        end
    end

    // Saturation can park cnt on DATA_BITS, so only the arriving step counts as completion.
    assign word_done = s & (cnt_next == DB5) & (trans | (cnt_reg != DB5));
    assign long_slot = s & ~trans & (cnt_reg == SB5);

    always_comb begin
        state_next     = state_reg;
        left_hold_next = left_hold_reg;
        push_next      = 1'b0;
        err_next       = 1'b0;
        case (state_reg)
            SEEK: begin
                if (rise)
                    state_next = LEFT;
            end
            LEFT: begin
                if (trans) begin
                    if (cnt_reg == SB5) begin
                        state_next = RIGHT;
                    end else begin
                        err_next   = 1'b1;
                        state_next = rise ? LEFT : SEEK;
                    end
                end else if (long_slot) begin
                    err_next   = 1'b1;
                    state_next = SEEK;
                end else if (word_done) begin
                    left_hold_next = shift_next;
                end
            end
            RIGHT: begin
                if (trans) begin
                    if (cnt_reg == SB5 && rise) begin
                        state_next = LEFT;
                    end else begin
                        err_next   = 1'b1;
                        state_next = rise ? LEFT : SEEK;
                    end
                end else if (long_slot) begin
                    err_next   = 1'b1;
                    state_next = SEEK;
                end else if (word_done) begin
                    push_next = 1'b1;
                end
            end
            default: state_next = SEEK;
        endcase
    end

    always_ff @(posedge bck) begin
        if (rst) begin
            lj_bck_r       <= 1'b0;
            lj_bck_rr      <= 1'b0;
            lj_data_r      <= 1'b0;
            lj_lrck_r      <= 1'b0;
            lrck_prev_reg  <= 1'b0;
            cnt_reg        <= '0;
            shift_reg      <= '0;
            left_hold_reg  <= '0;
            state_reg      <= SEEK;
            push_reg       <= 1'b0;
            push_left_reg  <= '0;
            push_right_reg <= '0;
            frame_err_reg  <= 1'b0;
        end else begin
            lj_bck_r      <= lj_bck;
            lj_bck_rr     <= lj_bck_r;
            lj_data_r     <= lj_data;
            lj_lrck_r     <= lj_lrck;
            if (s)
                lrck_prev_reg <= lj_lrck_r;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            left_hold_reg <= left_hold_next;
            state_reg     <= state_next;
            push_reg      <= push_next;
            frame_err_reg <= err_next;
            if (push_next) begin
                push_left_reg  <= left_hold_reg;
                push_right_reg <= shift_next;
            end
        end
    end

    // Pair FIFO: extra pointer bit distinguishes full from empty.
    assign level     = wr_ptr_reg - rd_ptr_reg;
    assign full      = (level == DEPTH_L);
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    assign wr_en     = push_reg & (~full | pop);

    always_ff @(posedge bck) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            overrun_reg <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_left[i]  <= '0;
                mem_right[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_left[wr_ptr_reg[AW-1:0]]  <= push_left_reg;
                mem_right[wr_ptr_reg[AW-1:0]] <= push_right_reg;
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push_reg && full && !pop)
                overrun_reg <= 1'b1;
        end
    end

    assign out_left  = mem_left[rd_ptr_reg[AW-1:0]];
    assign out_right = mem_right[rd_ptr_reg[AW-1:0]];
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

`ifdef LJ16_MONO_MIX_EN
    logic signed [DATA_BITS:0] mono_sum;
    assign mono_sum = $signed({out_left[DATA_BITS-1], out_left})
                    + $signed({out_right[DATA_BITS-1], out_right});
    assign out_mono = DATA_BITS'(mono_sum >>> 1);
`endif

endmodule

// File: tb/tb_lj16_frame_deserializer.sv
// Directed bench for lj16_frame_deserializer: serial frames in, collected pairs checked against tables.
module tb_lj16_frame_deserializer;

    logic        bck = 1'b0;
    logic        rst = 1'b1;
    logic        lj_bck = 1'b0, lj_data = 1'b0, lj_lrck = 1'b0;
    logic [15:0] out_left, out_right;
`ifdef LJ16_MONO_MIX_EN
    logic [15:0] out_mono;
`endif
    logic        out_valid, out_ready = 1'b1, frame_err, overrun;

    lj16_frame_deserializer dut (
        .bck(bck), .rst(rst), .lj_bck(lj_bck), .lj_data(lj_data), .lj_lrck(lj_lrck),
        .out_left(out_left), .out_right(out_right),
`ifdef LJ16_MONO_MIX_EN
        .out_mono(out_mono),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 bck = ~bck;

    typedef struct { logic [15:0] l; logic [15:0] r; } pair_t;
    typedef struct { logic [15:0] l_in; logic [15:0] r_in; logic [15:0] exp_l; logic [15:0] exp_r; } vec_t;

    pair_t rx_q[$];
    int checks = 0, errors = 0;
    int err_pulses = 0, err_run = 0, max_run = 0;

    always @(negedge bck) begin
        if (!rst) begin
            if (out_valid && out_ready) rx_q.push_back('{l: out_left, r: out_right});
            if (frame_err) begin
                if (err_run == 0) err_pulses++;
                err_run++;
                if (err_run > max_run) max_run = err_run;
            end else begin
                err_run = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    task automatic do_reset();
        @(posedge bck); #1;
        rst = 1'b1; lj_bck = 1'b0; lj_lrck = 1'b0; lj_data = 1'b0;
        repeat (2) @(posedge bck);
        #1 rst = 1'b0;
        rx_q.delete();
        err_pulses = 0; err_run = 0; max_run = 0;
    endtask

    task automatic send_bit(input logic lr, input logic d);
        @(posedge bck); #1;
        lj_bck = 1'b0; lj_lrck = lr; lj_data = d;
        @(posedge bck); #1;
        lj_bck = 1'b1;
    endtask

    task automatic send_slot(input logic lr, input logic [15:0] word, input int nbits);
        for (int i = 0; i < nbits; i++)
            send_bit(lr, (i < 16) ? word[15-i] : 1'b0);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b1, l, 16);
        send_slot(1'b0, r, 16);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge bck);
        #1;
    endtask

    function automatic logic [31:0] rx_word(input int idx, input bit right);
        if (idx >= rx_q.size()) return 32'hDEAD_BEEF;
        return right ? {16'h0, rx_q[idx].r} : {16'h0, rx_q[idx].l};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
        vecs[1] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
        vecs[2] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
        vecs[3] = '{16'h1234, 16'hABCD, 16'h1234, 16'hABCD};
        vecs[4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[5] = '{16'h0001, 16'h8000, 16'h0001, 16'h8000};

        // Reset state
        do_reset();
        check("reset_valid", {31'h0, out_valid}, 32'h0);
        check("reset_left", {16'h0, out_left}, 32'h0);
        check("reset_right", {16'h0, out_right}, 32'h0);
        check("reset_frame_err", {31'h0, frame_err}, 32'h0);
        check("reset_overrun", {31'h0, overrun}, 32'h0);

        // Clean frames from the table
        out_ready = 1'b1;
        foreach (vecs[i]) send_frame(vecs[i].l_in, vecs[i].r_in);
        idle(8);
        check("clean_count", rx_q.size(), 6);
        foreach (vecs[i]) begin
            check($sformatf("clean_left[%0d]", i), rx_word(i, 1'b0), {16'h0, vecs[i].exp_l});
            check($sformatf("clean_right[%0d]", i), rx_word(i, 1'b1), {16'h0, vecs[i].exp_r});
        end
        check("clean_frame_err", err_pulses, 0);
        check("clean_overrun", {31'h0, overrun}, 32'h0);

        // Latency: out_valid two bck cycles after lj_bck sampled high for right LSB
        do_reset();
        out_ready = 1'b0;
        send_slot(1'b1, 16'h5A5A, 16);
        send_slot(1'b0, 16'hC3C3, 15);
        @(posedge bck); #1; lj_bck = 1'b0; lj_data = 1'b1;
        @(posedge bck); #1; lj_bck = 1'b1;
        @(posedge bck); @(negedge bck);
        check("lat_valid_c0", {31'h0, out_valid}, 32'h0);
        @(posedge bck); @(negedge bck);
        check("lat_valid_c1", {31'h0, out_valid}, 32'h0);
        @(posedge bck); @(negedge bck);
        check("lat_valid_c2", {31'h0, out_valid}, 32'h1);
        check("lat_left", {16'h0, out_left}, 32'h5A5A);
        check("lat_right", {16'h0, out_right}, 32'hC3C3);

        // Stream starting mid right slot
        do_reset();
        out_ready = 1'b1;
        send_slot(1'b0, 16'hFFFF, 7);
        send_frame(16'h2468, 16'h1357);
        idle(8);
        check("midstart_count", rx_q.size(), 1);
        check("midstart_left", rx_word(0, 1'b0), 32'h2468);
        check("midstart_right", rx_word(0, 1'b1), 32'h1357);
        check("midstart_frame_err", err_pulses, 0);

        // Left slot cut to 12 bits
        do_reset();
        send_slot(1'b1, 16'hDEAD, 12);
        send_slot(1'b0, 16'hBEEF, 16);
        send_frame(16'h1234, 16'hABCD);
        idle(8);
        check("short_err_pulses", err_pulses, 1);
        check("short_err_width", max_run, 1);
        check("short_count", rx_q.size(), 1);
        check("short_left", rx_word(0, 1'b0), 32'h1234);
        check("short_right", rx_word(0, 1'b1), 32'hABCD);

        // Right slot stretched to 17 bits, then resync
        do_reset();
        send_slot(1'b1, 16'h0F0F, 16);
        send_slot(1'b0, 16'hF0F0, 17);
        send_frame(16'h5555, 16'hAAAA);
        idle(8);
        check("long_err_pulses", err_pulses, 1);
        check("long_err_width", max_run, 1);
        check("long_last_left", rx_word(rx_q.size() - 1, 1'b0), 32'h5555);
        check("long_last_right", rx_word(rx_q.size() - 1, 1'b1), 32'hAAAA);

        // Reset in the middle of a frame
        do_reset();
        send_slot(1'b1, 16'h1111, 16);
        send_slot(1'b0, 16'h2222, 8);
        do_reset();
        check("midrst_valid", {31'h0, out_valid}, 32'h0);
        send_frame(16'h3333, 16'h4444);
        idle(8);
        check("midrst_count", rx_q.size(), 1);
        check("midrst_left", rx_word(0, 1'b0), 32'h3333);
        check("midrst_right", rx_word(0, 1'b1), 32'h4444);

        // Backpressure: 4 frames into a 2-deep FIFO
        do_reset();
        out_ready = 1'b0;
        send_frame(16'hA001, 16'hB001);
        send_frame(16'hA002, 16'hB002);
        idle(8);
        check("bp_overrun_before", {31'h0, overrun}, 32'h0);
        send_frame(16'hA003, 16'hB003);
        send_frame(16'hA004, 16'hB004);
        idle(8);
        check("bp_valid", {31'h0, out_valid}, 32'h1);
        check("bp_overrun", {31'h0, overrun}, 32'h1);
        check("bp_head_left", {16'h0, out_left}, 32'hA001);
        check("bp_head_right", {16'h0, out_right}, 32'hB001);
        out_ready = 1'b1;
        idle(6);
        check("bp_count", rx_q.size(), 2);
        check("bp_left0", rx_word(0, 1'b0), 32'hA001);
        check("bp_right0", rx_word(0, 1'b1), 32'hB001);
        check("bp_left1", rx_word(1, 1'b0), 32'hA002);
        check("bp_right1", rx_word(1, 1'b1), 32'hB002);
        check("bp_valid_drained", {31'h0, out_valid}, 32'h0);
        check("bp_overrun_sticky", {31'h0, overrun}, 32'h1);

`ifdef LJ16_MONO_MIX_EN
        do_reset();
        out_ready = 1'b0;
        send_frame(16'h7FFF, 16'h7FFF);
        idle(8);
        check("mono_max", {16'h0, out_mono}, 32'h7FFF);
        do_reset();
        send_frame(16'h8000, 16'h0001);
        idle(8);
        check("mono_neg", {16'h0, out_mono}, 32'hC000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
